// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch front end between PC unit, instruction memory and decode
// Define FETCH_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES and fault the fetch on expiry.
module fetch_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  discard;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fetch_ready   <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            instr_valid   <= 1'b0;
            instr_data    <= '0;
            instr_pc      <= '0;
            instr_fault   <= 1'b0;
            discard       <= 1'b0;
            pc_q          <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A set discard here only comes from a timed-out fetch whose response is still owed.
                    if (discard && mem_resp_valid) begin
                        discard     <= 1'b0;
                        fetch_ready <= 1'b1;
                    end
                    if (fetch_valid && !flush && !discard) begin
                        pc_q        <= fetch_addr;
                        fetch_ready <= 1'b0;
                        if (fetch_addr[1:0] != 2'b00) begin
                            state       <= HOLD;
                            instr_valid <= 1'b1;
                            instr_fault <= 1'b1;
                            instr_data  <= '0;
                            instr_pc    <= fetch_addr;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= fetch_addr;
                        end
                    end
                end
                REQ: begin
                    if (flush) discard <= 1'b1;
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (discard || flush) begin
                            state       <= IDLE;
                            discard     <= 1'b0;
                            fetch_ready <= 1'b1;
                        end else begin
                            state       <= HOLD;
                            instr_valid <= 1'b1;
                            instr_data  <= mem_resp_data;
                            instr_pc    <= pc_q;
                            instr_fault <= 1'b0;
                        end
                    end else begin
                        if (flush) discard <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        if (timeout) begin
                            // The response is still owed; keep discard set so it is dropped on arrival.
                            discard <= 1'b1;
                            if (discard || flush) begin
                                state <= IDLE;
                            end else begin
                                state       <= HOLD;
                                instr_valid <= 1'b1;
                                instr_fault <= 1'b1;
                                instr_data  <= '0;
                                instr_pc    <= pc_q;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (discard && mem_resp_valid) discard <= 1'b0;
                    if (flush || instr_ready) begin
                        state       <= IDLE;
                        instr_valid <= 1'b0;
                        fetch_ready <= !discard || mem_resp_valid;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    resp_only_when_expected: assert property (@(posedge clk) disable iff (rst)
        mem_resp_valid |-> (state == WAIT || discard));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit against a transaction-level model of fetched instructions
module tb_fetch_unit;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_addr = '0;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_fault;

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_pc(instr_pc), .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    // Model: instructions owed to decode in order, plus the memory request/response still outstanding.
    exp_t        q[$];
    bit          req_pend = 1'b0;
    bit          resp_pend = 1'b0;
    bit          late = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] maddr = '0;
    int          mcnt = -1;
    int          waited = 0;
    int          resp_delay = 1;
    bit          resp_never = 1'b0;
    bit          late_fire = 1'b0;
    bit          armed = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0200: return 32'hDEAD_BEEF;
            32'h0000_0020: return 32'h1111_1111;
            32'h0000_0080: return 32'h2222_0080;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    function automatic bit m_idle();
        return q.size() == 0 && !req_pend && !resp_pend && !late;
    endfunction

    function automatic bit m_vis();
        return q.size() > 0 && !req_pend && !resp_pend;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: update the model from pre-edge inputs, then drive the memory side.
    task automatic tick();
        bit          hs, acc, rsp, fl, vis;
        logic [31:0] fa;
        @(posedge clk);
        vis = m_vis();
        hs  = fetch_valid && m_idle() && !flush;
        fa  = fetch_addr;
        acc = req_pend && mem_req_ready;
        rsp = mem_resp_valid;
        fl  = flush;
        #1;
        cyc++;
        if (rst) begin
            q.delete();
            req_pend = 1'b0; resp_pend = 1'b0; late = 1'b0;
            mcnt = -1; waited = 0;
            mem_resp_valid = 1'b0;
        end else begin
            if (fl) q.delete();
            else if (vis && instr_ready) void'(q.pop_front());
            if (rsp) begin
                resp_pend = 1'b0;
                late      = 1'b0;
            end else if (resp_pend) begin
`ifdef FETCH_TIMEOUT_EN
                if (waited == TO - 1) begin
                    resp_pend = 1'b0;
                    late      = 1'b1;
                end else
`endif
                waited++;
            end
            if (acc) begin
                req_pend  = 1'b0;
                resp_pend = 1'b1;
                waited    = 0;
                maddr     = req_addr;
                mcnt      = resp_never ? -1 : resp_delay;
            end
            if (hs) begin
                if (fa[1:0] != 2'b00) begin
                    q.push_back('{fa, 32'h0, 1'b1});
                end else begin
                    q.push_back('{fa, resp_never ? 32'h0 : mem_word(fa), resp_never});
                    req_pend = 1'b1;
                    req_addr = fa;
                end
            end
            mem_resp_valid = 1'b0;
            if (late_fire) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hBAD0_0BAD;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(maddr);
                    mcnt           = -1;
                end
            end
        end
    endtask

    task automatic wait_instr(inout int lat);
        while (!instr_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk1("instr_arrives", instr_valid, 1'b1);
    endtask

    task automatic do_fetch(input logic [31:0] addr, output int lat);
        int n = 0;
        fetch_addr  = addr;
        fetch_valid = 1'b1;
        while (!m_idle() && n < 50) begin
            tick();
            n++;
        end
        tick();
        fetch_valid = 1'b0;
        lat = 1;
        wait_instr(lat);
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk1("rst_fetch_ready", fetch_ready, 1'b1);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk32("rst_mem_req_addr", mem_req_addr, 32'h0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk32("rst_instr_data", instr_data, 32'h0);
        chk32("rst_instr_pc", instr_pc, 32'h0);
        chk1("rst_instr_fault", instr_fault, 1'b0);
    endtask

    initial begin : compare
        bit vis;
        forever begin
            @(negedge clk);
            if (armed) begin
                vis = m_vis();
                chk1("instr_valid", instr_valid, vis);
                if (vis) begin
                    chk32("instr_pc", instr_pc, q[0].pc);
                    chk32("instr_data", instr_data, q[0].data);
                    chk1("instr_fault", instr_fault, q[0].fault);
                end
                chk1("fetch_ready", fetch_ready, m_idle());
                chk1("mem_req_valid", mem_req_valid, req_pend);
                if (req_pend) chk32("mem_req_addr", mem_req_addr, req_addr);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        rst = 1'b1;
        tick();
        armed = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state();

        // Aligned fetch, zero-wait memory: instr_valid three cycles after the handshake.
        do_fetch(32'h0000_0000, lat);
        chk_int("latency_zero_wait", lat, 3);
        chk32("first_data", instr_data, 32'h0000_0013);
        chk32("first_pc", instr_pc, 32'h0000_0000);
        chk1("first_fault", instr_fault, 1'b0);
        consume();

        // Request held stable while memory stalls.
        mem_req_ready = 1'b0;
        fetch_addr = 32'h0000_0104;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("stall_req_valid", mem_req_valid, 1'b1);
            chk32("stall_req_addr", mem_req_addr, 32'h0000_0104);
            tick();
        end
        mem_req_ready = 1'b1;
        lat = 0;
        wait_instr(lat);
        chk32("stall_pc", instr_pc, 32'h0000_0104);
        consume();

        // Decoder backpressure in HOLD.
        do_fetch(32'h0000_0200, lat);
        for (int i = 0; i < 5; i++) begin
            chk32("hold_data", instr_data, 32'hDEAD_BEEF);
            chk1("hold_fetch_ready", fetch_ready, 1'b0);
            tick();
        end
        consume();
        chk1("after_hold_fetch_ready", fetch_ready, 1'b1);

        // Flush in WAIT; the stale response two cycles later must be dropped.
        resp_delay = 3;
        fetch_addr = 32'h0000_0020;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("flushed_no_instr", instr_valid, 1'b0);
            tick();
        end
        chk1("flushed_fetch_ready", fetch_ready, 1'b1);
        resp_delay = 1;
        do_fetch(32'h0000_0080, lat);
        chk32("post_flush_pc", instr_pc, 32'h0000_0080);
        chk32("post_flush_data", instr_data, 32'h2222_0080);
        consume();

        // Flush in REQ: the request still completes, its data is dropped.
        mem_req_ready = 1'b0;
        fetch_addr = 32'h0000_0040;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("req_flush_req_held", mem_req_valid, 1'b1);
        chk32("req_flush_addr_held", mem_req_addr, 32'h0000_0040);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk1("req_flush_no_instr", instr_valid, 1'b0);
        chk1("req_flush_ready", fetch_ready, 1'b1);

        // Flush in HOLD wins over a simultaneous instr_ready.
        do_fetch(32'h0000_0044, lat);
        flush = 1'b1;
        instr_ready = 1'b1;
        tick();
        flush = 1'b0;
        instr_ready = 1'b0;
        chk1("hold_flush_valid", instr_valid, 1'b0);
        chk1("hold_flush_ready", fetch_ready, 1'b1);

        // Misaligned PC faults without touching memory.
        do_fetch(32'h0000_0006, lat);
        chk_int("misaligned_latency", lat, 1);
        chk1("misaligned_fault", instr_fault, 1'b1);
        chk32("misaligned_pc", instr_pc, 32'h0000_0006);
        chk32("misaligned_data", instr_data, 32'h0);
        consume();

        // Flush in IDLE masks fetch_valid.
        fetch_addr = 32'h0000_0008;
        fetch_valid = 1'b1;
        flush = 1'b1;
        tick();
        fetch_valid = 1'b0;
        flush = 1'b0;
        chk1("idle_flush_ready", fetch_ready, 1'b1);
        chk1("idle_flush_no_req", mem_req_valid, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        // No response: fault after TO WAIT cycles, late response dropped, then normal service.
        resp_never = 1'b1;
        do_fetch(32'h0000_0300, lat);
        resp_never = 1'b0;
        chk_int("timeout_latency", lat, 10);
        chk1("timeout_fault", instr_fault, 1'b1);
        chk32("timeout_pc", instr_pc, 32'h0000_0300);
        consume();
        chk1("timeout_stall_ready", fetch_ready, 1'b0);
        late_fire = 1'b1;
        tick();
        late_fire = 1'b0;
        tick();
        chk1("late_resp_clears", fetch_ready, 1'b1);
        do_fetch(32'h0000_0084, lat);
        chk_int("after_timeout_latency", lat, 3);
        chk32("after_timeout_data", instr_data, 32'hA5A5_0084);
        consume();
`endif

        // Reset in the middle of a transaction.
        fetch_addr = 32'h0000_0010;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
